uni_shift_deserializer: RTL



---
 rtl/uni_shift_deserializer.sv | 119 +++++++++++
 1 files changed

// File: rtl/uni_shift_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH framed serial bits (MSB- or LSB-first) into a word.
// Latency: data_valid rises on the edge that captures the final bit (visible the following cycle).
// Backpressure: one-word valid/ready holding register; a word completing while the held word is
//               unaccepted is dropped and sets the sticky overrun flag (cleared only by reset).
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   serial_input, bit_valid serial bit and its qualifier
//   frame_start             marks the current valid bit as bit 0 of a new word
//   msb_first               bit order for the frame, latched on frame_start
//   data_ready              consumer accepts data_output this cycle
//   data_output, data_valid last completed word and its valid flag
//   overrun                 sticky: a completed word was dropped
//   busy                    a frame is in progress
module uni_shift_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_input,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             msb_first,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_output,
    output logic             data_valid,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic               order_q, order_d;
    logic               word_done;

    logic [WIDTH-1:0]   data_output_d;
    logic               data_valid_d;
    logic               overrun_d;

    // State register, including the holding register and sticky flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            sreg_q      <= '0;
            order_q     <= 1'b0;
            data_output <= '0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sreg_q      <= sreg_d;
            order_q     <= order_d;
            data_output <= data_output_d;
            data_valid  <= data_valid_d;
            overrun     <= overrun_d;
        end
    end

    // Next-state: frame alignment, bit capture and completion detection.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        sreg_d    = sreg_q;
        order_d   = order_q;
        word_done = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                // Start (or restart) a frame; any partial word is discarded by
                // loading only the new bit 0 at the position its order dictates.
                state_d = SHIFT;
                count_d = CNT_W'(1);
                order_d = msb_first;
                sreg_d  = msb_first ? {{(WIDTH-1){1'b0}}, serial_input}
                                    : {serial_input, {(WIDTH-1){1'b0}}};
            end else if (state_q == SHIFT) begin
                sreg_d = order_q ? {sreg_q[WIDTH-2:0], serial_input}
                                 : {serial_input, sreg_q[WIDTH-1:1]};
                if (count_q == LAST_BIT) begin
                    word_done = 1'b1;
                    count_d   = '0;
                    state_d   = IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        end
    end

    // Outputs: busy flag and the holding-register update.
    always_comb begin
        busy          = (state_q == SHIFT);
        data_output_d = data_output;
        data_valid_d  = data_valid;
        overrun_d     = overrun;
        if (word_done) begin
            // Register free, or its word is being accepted on this same edge.
            if (!data_valid || data_ready) begin
                data_output_d = sreg_d;
                data_valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

endmodule
